// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA read path: scheduler state encoding and
// the bytes-per-beat helper used for address stepping.
package vdma_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } rbs_state_e;

  localparam int unsigned AXI_DSIZE_DEFAULT = 256;
  localparam int unsigned BYTES_PER_BEAT    = AXI_DSIZE_DEFAULT / 8;

  function automatic int unsigned beat_bytes(input int unsigned dsize);
    return dsize / 8;
  endfunction

endpackage

// File: rtl/burst_len_sel.sv
// Picks the next burst length: min(remaining beats, normal burst length),
// flagging short (tail) bursts and an exhausted frame.
module burst_len_sel #(
  parameter int unsigned NOR_BURST_LEN = 200,
  parameter int unsigned LSIZE         = 9
) (
  input  logic [31:0]      i_remain,
  output logic [LSIZE-1:0] o_cur_len,
  output logic             o_is_tail,
  output logic             o_is_zero
);
  import vdma_pkg::*;

  localparam logic [31:0]      NOR32   = 32'(NOR_BURST_LEN);
  localparam logic [LSIZE-1:0] NOR_LEN = LSIZE'(NOR_BURST_LEN);

  // Length clamp and tail classification
  always_comb begin
    o_cur_len = {LSIZE{1'b0}};
    o_is_tail = 1'b0;
    o_is_zero = (i_remain == 32'd0);
    if (i_remain >= NOR32) begin
      o_cur_len = NOR_LEN;
      o_is_tail = 1'b0;
    end else begin
      o_cur_len = LSIZE'(i_remain);
      o_is_tail = ~o_is_zero;
    end
  end

endmodule

// File: rtl/read_burst_scheduler.sv
// Splits a frame read into AXI bursts of NOR_BURST_LEN beats plus one tail,
// issuing one command at a time and only when the downstream FIFO has room.
module read_burst_scheduler #(
  parameter int unsigned NOR_BURST_LEN = 200,
  parameter int unsigned LSIZE         = 9,
  parameter int unsigned AXI_DSIZE     = 256,
  parameter int unsigned ASIZE         = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             fsync,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [31:0]      total_beats,
  input  logic [15:0]      fifo_space,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [ASIZE-1:0] cmd_addr,
  output logic [LSIZE-1:0] cmd_len,
  input  logic             data_last,
  output logic             burst_done,
  output logic             tail_done,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);
  import vdma_pkg::*;

  localparam logic [ASIZE-1:0] BPB = ASIZE'(beat_bytes(AXI_DSIZE));

  rbs_state_e       r_state;
  rbs_state_e       w_next;
  logic [ASIZE-1:0] r_addr;
  logic [31:0]      r_remain;
  logic             r_restart_pend;
  logic             r_tail;

  logic [31:0]      w_sel_remain;
  logic [ASIZE-1:0] w_sel_addr;
  logic [LSIZE-1:0] w_cur_len;
  logic             w_is_tail;
  logic             w_is_zero;
  logic             w_space_ok;
  logic             w_restart;
  logic             w_handshake;
  logic             w_enter_issue;

  // LOAD evaluates the first burst straight from the inputs so a frame with
  // room available goes LOAD -> ISSUE without an extra CHECK cycle.
  assign w_sel_remain = (r_state == S_LOAD) ? total_beats : r_remain;
  assign w_sel_addr   = (r_state == S_LOAD) ? base_addr   : r_addr;

  burst_len_sel #(
    .NOR_BURST_LEN (NOR_BURST_LEN),
    .LSIZE         (LSIZE)
  ) u_len_sel (
    .i_remain  (w_sel_remain),
    .o_cur_len (w_cur_len),
    .o_is_tail (w_is_tail),
    .o_is_zero (w_is_zero)
  );

  assign w_space_ok    = ({16'd0, fifo_space} >= 32'(w_cur_len));
  assign w_restart     = r_restart_pend | (fsync & (r_state != S_IDLE));
  assign w_handshake   = (r_state == S_ISSUE) & cmd_ready;
  assign w_enter_issue = (w_next == S_ISSUE) & (r_state != S_ISSUE);

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (fsync) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_restart || w_is_zero || !w_space_ok) begin
          w_next = S_CHECK;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_CHECK: begin
        if (w_restart) begin
          w_next = S_LOAD;
        end else if (w_is_zero) begin
          w_next = S_DONE;
        end else if (w_space_ok) begin
          w_next = S_ISSUE;
        end else begin
          w_next = S_CHECK;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          w_next = S_WAIT;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (data_last && w_restart) begin
          w_next = S_LOAD;
        end else if (data_last) begin
          w_next = S_CHECK;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE: begin
        if (w_restart) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, frame bookkeeping and registered outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_addr         <= {ASIZE{1'b0}};
      r_remain       <= 32'd0;
      r_restart_pend <= 1'b0;
      r_tail         <= 1'b0;
      cmd_valid      <= 1'b0;
      cmd_addr       <= {ASIZE{1'b0}};
      cmd_len        <= {LSIZE{1'b0}};
      burst_done     <= 1'b0;
      tail_done      <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_restart_pend <= (w_next == S_LOAD) ? 1'b0 : w_restart;
      cmd_valid      <= (w_next == S_ISSUE);
      burst_done     <= (r_state == S_WAIT) & data_last & ~r_tail;
      tail_done      <= (r_state == S_WAIT) & data_last & r_tail;
      frame_done     <= (w_next == S_DONE);
      busy           <= (w_next != S_IDLE);
      overrun        <= fsync & (r_state != S_IDLE);

      if (r_state == S_LOAD) begin
        r_addr   <= base_addr;
        r_remain <= total_beats;
      end else if (w_handshake) begin
        r_addr   <= r_addr + (ASIZE'(cmd_len) * BPB);
        r_remain <= r_remain - 32'(cmd_len);
      end else begin
        r_addr   <= r_addr;
        r_remain <= r_remain;
      end

      // Command fields freeze on ISSUE entry and stay put until the handshake
      if (w_enter_issue) begin
        cmd_addr <= w_sel_addr;
        cmd_len  <= w_cur_len;
        r_tail   <= w_is_tail;
      end else begin
        cmd_addr <= cmd_addr;
        cmd_len  <= cmd_len;
        r_tail   <= r_tail;
      end
    end
  end

endmodule

// File: tb/tb_read_burst_scheduler.sv
// Directed bench for read_burst_scheduler: frame splitting, timing,
// back-pressure, overrun restart and reset recovery.
module tb_read_burst_scheduler;

  logic        clock;
  logic        rst_n;
  logic        fsync;
  logic [31:0] base_addr;
  logic [31:0] total_beats;
  logic [15:0] fifo_space;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        resp_last;
  logic        force_last;
  logic        data_last;
  logic        burst_done;
  logic        tail_done;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  int checks;
  int failures;
  int cyc;
  int resp_delay;
  int n_burst, n_tail, n_frame, n_ovr;
  int td_cyc, fd_cyc;
  logic [31:0] q_addr[$];
  logic [8:0]  q_len[$];

  assign data_last = resp_last | force_last;

  read_burst_scheduler dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .fsync       (fsync),
    .base_addr   (base_addr),
    .total_beats (total_beats),
    .fifo_space  (fifo_space),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .data_last   (data_last),
    .burst_done  (burst_done),
    .tail_done   (tail_done),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    n_burst = 0; n_tail = 0; n_frame = 0; n_ovr = 0;
    td_cyc = 0; fd_cyc = 0;
    q_addr.delete();
    q_len.delete();
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
  endtask

  // which: 0 = frames, 1 = commands
  task automatic wait_cnt(input string tag, input int which, input int n, input int budget);
    int k;
    int have;
    k = 0;
    have = (which == 0) ? n_frame : q_addr.size();
    while (have < n && k < budget) begin
      tick();
      k++;
      have = (which == 0) ? n_frame : q_addr.size();
    end
    if (have < n) check_val(tag, 64'(have), 64'(n));
  endtask

  // Event log sampled mid-cycle
  initial begin
    clear_log();
    forever begin
      @(negedge clock);
      if (cmd_valid && cmd_ready) begin
        q_addr.push_back(cmd_addr);
        q_len.push_back(cmd_len);
      end
      if (burst_done) n_burst++;
      if (tail_done) begin n_tail++; td_cyc = cyc; end
      if (frame_done) begin n_frame++; fd_cyc = cyc; end
      if (overrun) n_ovr++;
    end
  end

  // Memory model: returns data_last resp_delay cycles after each handshake
  initial begin
    resp_last = 1'b0;
    forever begin
      @(negedge clock);
      if (cmd_valid && cmd_ready) begin
        repeat (resp_delay) @(posedge clock);
        #1 resp_last = 1'b1;
        @(posedge clock);
        #1 resp_last = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int bad;
    logic [31:0] a0;
    logic [8:0]  l0;
    checks = 0; failures = 0;
    rst_n = 1'b0; fsync = 1'b0; base_addr = 32'd0; total_beats = 32'd0;
    fifo_space = 16'd512; cmd_ready = 1'b1; force_last = 1'b0; resp_delay = 3;
    #23;
    check_val("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    check_val("rst_cmd_len", 64'(cmd_len), 64'd0);
    check_val("rst_pulses", 64'({burst_done, tail_done, frame_done, overrun}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // data_last while idle is ignored
    force_last = 1'b1;
    tick();
    force_last = 1'b0;
    tick();
    check_val("idle_last_busy", 64'(busy), 64'd0);
    check_val("idle_last_done", 64'(n_burst + n_tail), 64'd0);

    // 450 beats: two normal bursts plus a 50-beat tail
    clear_log();
    base_addr = 32'h1000_0000; total_beats = 32'd450;
    pulse_fsync();
    check_val("t1_valid_n1", 64'(cmd_valid), 64'd0);
    check_val("t1_busy_n1", 64'(busy), 64'd1);
    tick();
    check_val("t1_valid_n2", 64'(cmd_valid), 64'd1);
    wait_cnt("t1_frame_timeout", 0, 1, 200);
    repeat (3) tick();
    check_val("t1_ncmd", 64'(q_addr.size()), 64'd3);
    if (q_addr.size() == 3) begin
      check_val("t1_addr0", 64'(q_addr[0]), 64'h1000_0000);
      check_val("t1_addr1", 64'(q_addr[1]), 64'h1000_1900);
      check_val("t1_addr2", 64'(q_addr[2]), 64'h1000_3200);
      check_val("t1_len0", 64'(q_len[0]), 64'd200);
      check_val("t1_len1", 64'(q_len[1]), 64'd200);
      check_val("t1_len2", 64'(q_len[2]), 64'd50);
    end
    check_val("t1_burst_done", 64'(n_burst), 64'd2);
    check_val("t1_tail_done", 64'(n_tail), 64'd1);
    check_val("t1_frame_done", 64'(n_frame), 64'd1);
    check_val("t1_fd_after_tail", 64'(fd_cyc - td_cyc), 64'd1);
    check_val("t1_idle", 64'(busy), 64'd0);

    // Exact multiple: no tail
    clear_log();
    base_addr = 32'h0000_2000; total_beats = 32'd400;
    pulse_fsync();
    wait_cnt("t2_frame_timeout", 0, 1, 200);
    repeat (3) tick();
    check_val("t2_ncmd", 64'(q_addr.size()), 64'd2);
    check_val("t2_burst_done", 64'(n_burst), 64'd2);
    check_val("t2_tail_done", 64'(n_tail), 64'd0);
    check_val("t2_frame_done", 64'(n_frame), 64'd1);

    // Empty frame
    clear_log();
    total_beats = 32'd0;
    c0 = cyc;
    pulse_fsync();
    repeat (3) tick();
    check_val("t3_frame_cycle", 64'(fd_cyc - c0), 64'd3);
    check_val("t3_busy_n4", 64'(busy), 64'd0);
    check_val("t3_ncmd", 64'(q_addr.size()), 64'd0);
    check_val("t3_frame_done", 64'(n_frame), 64'd1);

    // FIFO back-pressure: 150 free beats cannot take a 200-beat burst
    clear_log();
    base_addr = 32'h0000_3000; total_beats = 32'd450; fifo_space = 16'd150;
    pulse_fsync();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_valid) bad++;
    end
    check_val("t4_valid_low", 64'(bad), 64'd0);
    fifo_space = 16'd300;
    check_val("t4_valid_at_rise", 64'(cmd_valid), 64'd0);
    tick();
    check_val("t4_valid_after_rise", 64'(cmd_valid), 64'd1);
    check_val("t4_addr0", 64'(cmd_addr), 64'h0000_3000);
    wait_cnt("t4_frame_timeout", 0, 1, 200);
    repeat (3) tick();
    check_val("t4_ncmd", 64'(q_addr.size()), 64'd3);
    if (q_addr.size() == 3) check_val("t4_addr2", 64'(q_addr[2]), 64'h0000_6200);
    fifo_space = 16'd512;

    // cmd_ready held low: command fields must not move
    clear_log();
    cmd_ready = 1'b0;
    base_addr = 32'h0000_4000; total_beats = 32'd200;
    pulse_fsync();
    tick();
    check_val("t5_valid", 64'(cmd_valid), 64'd1);
    a0 = cmd_addr; l0 = cmd_len;
    check_val("t5_addr", 64'(a0), 64'h0000_4000);
    check_val("t5_len", 64'(l0), 64'd200);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!cmd_valid || cmd_addr !== a0 || cmd_len !== l0) bad++;
    end
    check_val("t5_stable", 64'(bad), 64'd0);
    cmd_ready = 1'b1;
    wait_cnt("t5_frame_timeout", 0, 1, 200);
    repeat (3) tick();
    check_val("t5_burst_done", 64'(n_burst), 64'd1);
    check_val("t5_ncmd", 64'(q_addr.size()), 64'd1);

    // fsync during the second burst's WAIT restarts at the new base
    clear_log();
    resp_delay = 8;
    base_addr = 32'h0000_5000; total_beats = 32'd450;
    pulse_fsync();
    wait_cnt("t6_cmd2_timeout", 1, 2, 200);
    repeat (2) tick();
    base_addr = 32'h9000_0000; total_beats = 32'd200;
    pulse_fsync();
    check_val("t6_overrun", 64'(overrun), 64'd1);
    tick();
    check_val("t6_overrun_pulse", 64'(overrun), 64'd0);
    wait_cnt("t6_cmd3_timeout", 1, 3, 200);
    check_val("t6_no_frame_yet", 64'(n_frame), 64'd0);
    wait_cnt("t6_frame_timeout", 0, 1, 200);
    repeat (3) tick();
    check_val("t6_ncmd", 64'(q_addr.size()), 64'd3);
    if (q_addr.size() == 3) begin
      check_val("t6_addr1", 64'(q_addr[1]), 64'h0000_6900);
      check_val("t6_addr2", 64'(q_addr[2]), 64'h9000_0000);
      check_val("t6_len2", 64'(q_len[2]), 64'd200);
    end
    check_val("t6_burst_done", 64'(n_burst), 64'd3);
    check_val("t6_tail_done", 64'(n_tail), 64'd0);
    check_val("t6_overrun_cnt", 64'(n_ovr), 64'd1);
    check_val("t6_frame_done", 64'(n_frame), 64'd1);

    // Reset mid-burst, then recover with a short frame
    clear_log();
    resp_delay = 3;
    base_addr = 32'h0000_7000; total_beats = 32'd450;
    pulse_fsync();
    wait_cnt("t7_cmd_timeout", 1, 1, 50);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("t7_rst_busy", 64'(busy), 64'd0);
    check_val("t7_rst_valid", 64'(cmd_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check_val("t7_stay_idle", 64'(busy), 64'd0);
    clear_log();
    base_addr = 32'h0000_8000; total_beats = 32'd50;
    pulse_fsync();
    wait_cnt("t7_frame_timeout", 0, 1, 100);
    repeat (3) tick();
    check_val("t7_ncmd", 64'(q_addr.size()), 64'd1);
    if (q_addr.size() == 1) check_val("t7_len", 64'(q_len[0]), 64'd50);
    check_val("t7_tail_done", 64'(n_tail), 64'd1);
    check_val("t7_burst_done", 64'(n_burst), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
